fp8_result_queue: RTL and testbench

FP8_RESULT_QUEUE -- requirements
Module: fp8_result_queue

---
 rtl/fp8_result_queue.sv | 112 +++++++++++
 tb/tb_fp8_result_queue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fp8_result_queue.sv
// ============================================================================
// fp8_result_queue : first-word-fall-through queue for FP8 ALU results, with
//                    sticky exception flags and a saturating drop counter.
// Revision 1.0
// ============================================================================
`default_nettype none

module fp8_result_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [7:0]               in_result,
   input  logic [2:0]               in_op,
   input  logic [3:0]               in_flags,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               out_result,
   output logic [2:0]               out_op,
   output logic [3:0]               out_flags,
   output logic [$clog2(DEPTH):0]   count,
   output logic [2:0]               sticky_flags,
   output logic [7:0]               drop_count,
   input  logic                     sticky_clr
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [14:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic [2:0]    sticky_q;
   logic [7:0]    drop_q;

   logic          push;
   logic          pop;
   logic          drop;
   logic [14:0]   head;

   assign in_ready  = (count_q < CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign drop      = in_valid && !in_ready;

   assign count        = count_q;
   assign sticky_flags = sticky_q;
   assign drop_count   = drop_q;

   // Head is masked so idle outputs read as zero rather than stale storage.
   assign head       = out_valid ? mem[rd_ptr] : 15'd0;
   assign out_op     = head[14:12];
   assign out_flags  = head[11:8];
   assign out_result = head[7:0];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_op, in_flags, in_result};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   // New events take priority over a clear issued in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_q <= 3'b000;
         drop_q   <= 8'd0;
      end else begin
         if (push) begin
            sticky_q <= (sticky_clr ? 3'b000 : sticky_q) | in_flags[3:1];
         end else if (sticky_clr) begin
            sticky_q <= 3'b000;
         end

         if (drop) begin
            if (sticky_clr) begin
               drop_q <= 8'd1;
            end else if (drop_q != 8'hFF) begin
               drop_q <= drop_q + 8'd1;
            end
         end else if (sticky_clr) begin
            drop_q <= 8'd0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fp8_result_queue.sv
// ============================================================================
// tb_fp8_result_queue : directed scoreboard bench for fp8_result_queue.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fp8_result_queue;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_result;
   logic [2:0] in_op;
   logic [3:0] in_flags;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_result;
   logic [2:0] out_op;
   logic [3:0] out_flags;
   logic [$clog2(DEPTH):0] count;
   logic [2:0] sticky_flags;
   logic [7:0] drop_count;
   logic       sticky_clr;

   int n_cmp = 0;
   int n_bad = 0;
   logic [14:0] exp_q[$];

   fp8_result_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_op(in_op), .in_flags(in_flags),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_op(out_op), .out_flags(out_flags),
      .count(count), .sticky_flags(sticky_flags), .drop_count(drop_count),
      .sticky_clr(sticky_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted pop is compared against the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pop", {17'd0, out_op, out_flags, out_result}, 32'hFFFF_FFFF);
         end else begin
            check("pop_entry", {17'd0, out_op, out_flags, out_result}, {17'd0, exp_q[0]});
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one beat for one clock; acc says whether the bench expects acceptance.
   task automatic beat(input logic v, input logic [7:0] r, input logic [2:0] o,
                       input logic [3:0] f, input logic rdy, input logic acc);
      in_valid  = v;
      in_result = r;
      in_op     = o;
      in_flags  = f;
      out_ready = rdy;
      if (acc) exp_q.push_back({o, f, r});
      step();
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) beat(1'b0, 8'h00, 3'd0, 4'd0, rdy, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_result = '0; in_op = '0; in_flags = '0;
      out_ready = 1'b0; sticky_clr = 1'b0;
      step(); step();
      rst = 1'b0;

      // Reset state
      check("rst_count", 32'(count), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_result", 32'(out_result), 0);
      check("rst_sticky", 32'(sticky_flags), 0);
      check("rst_drop", 32'(drop_count), 0);

      // Fall-through latency
      beat(1'b1, 8'h48, 3'b010, 4'b0000, 1'b0, 1'b1);
      in_valid = 1'b0;
      check("ft_out_valid", 32'(out_valid), 1);
      check("ft_out_result", 32'(out_result), 32'h48);
      check("ft_out_op", 32'(out_op), 32'h2);
      check("ft_count", 32'(count), 1);
      idle(1, 1'b1);
      check("ft_drained", 32'(count), 0);
      check("idle_zero_data", {20'd0, out_op, out_flags, out_result}, 0);

      // Fill, drop, drain, then wrap
      for (int i = 0; i < 4; i++) beat(1'b1, 8'(8'h11 + i), 3'(i), 4'd0, 1'b0, 1'b1);
      check("full_in_ready", 32'(in_ready), 0);
      beat(1'b1, 8'h15, 3'd4, 4'd0, 1'b0, 1'b0);
      check("full_drop", 32'(drop_count), 1);
      check("full_count", 32'(count), 4);
      idle(4, 1'b1);
      check("drain_count", 32'(count), 0);
      for (int i = 0; i < 6; i++) beat(1'b1, 8'(8'h21 + i), 3'(7 - i), 4'd0, 1'b1, 1'b1);
      check("wrap_count", 32'(count), 1);
      idle(1, 1'b1);
      check("wrap_drained", 32'(count), 0);

      // Simultaneous push and pop at count=2
      beat(1'b1, 8'h40, 3'd1, 4'd0, 1'b0, 1'b1);
      beat(1'b1, 8'h41, 3'd2, 4'd0, 1'b0, 1'b1);
      beat(1'b1, 8'h30, 3'd3, 4'd0, 1'b1, 1'b1);
      in_valid = 1'b0;
      check("sim_count", 32'(count), 2);
      check("sim_head", 32'(out_result), 32'h41);
      idle(2, 1'b1);

      // Sticky flag accumulation and clear-with-push
      sticky_clr = 1'b1;
      idle(1, 1'b0);
      sticky_clr = 1'b0;
      check("clr_drop", 32'(drop_count), 0);
      check("clr_sticky", 32'(sticky_flags), 0);
      beat(1'b1, 8'h01, 3'd5, 4'b0100, 1'b1, 1'b1);
      beat(1'b1, 8'h02, 3'd5, 4'b1000, 1'b1, 1'b1);
      beat(1'b1, 8'h03, 3'd5, 4'b0001, 1'b1, 1'b1);
      check("sticky_acc", 32'(sticky_flags), 32'b110);
      sticky_clr = 1'b1;
      beat(1'b1, 8'h04, 3'd6, 4'b0010, 1'b1, 1'b1);
      sticky_clr = 1'b0;
      check("sticky_clr_push", 32'(sticky_flags), 32'b001);
      idle(2, 1'b1);

      // Clear together with a rejected push
      for (int i = 0; i < 4; i++) beat(1'b1, 8'(8'h50 + i), 3'd1, 4'd0, 1'b0, 1'b1);
      beat(1'b1, 8'h5F, 3'd1, 4'd0, 1'b0, 1'b0);
      sticky_clr = 1'b1;
      beat(1'b1, 8'h5E, 3'd1, 4'b1110, 1'b0, 1'b0);
      sticky_clr = 1'b0;
      check("clr_drop_wins", 32'(drop_count), 1);
      check("clr_sticky_on_drop", 32'(sticky_flags), 0);

      // Reset mid-operation at count=3
      idle(1, 1'b1);
      check("pre_rst_count", 32'(count), 3);
      rst = 1'b1;
      in_valid = 1'b1; in_result = 8'hEE; out_ready = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      exp_q.delete();
      check("mid_rst_count", 32'(count), 0);
      check("mid_rst_out_valid", 32'(out_valid), 0);
      check("mid_rst_in_ready", 32'(in_ready), 1);
      check("mid_rst_sticky", 32'(sticky_flags), 0);
      check("mid_rst_drop", 32'(drop_count), 0);

      // Drop counter saturation
      for (int i = 0; i < 4; i++) beat(1'b1, 8'(8'hA0 + i), 3'd7, 4'd0, 1'b0, 1'b1);
      for (int i = 0; i < 300; i++) beat(1'b1, 8'hFF, 3'd0, 4'd0, 1'b0, 1'b0);
      check("sat_drop", 32'(drop_count), 255);
      check("sat_count", 32'(count), 4);
      for (int i = 0; i < 5; i++) beat(1'b1, 8'hFF, 3'd0, 4'd0, 1'b0, 1'b0);
      check("sat_hold", 32'(drop_count), 255);
      idle(4, 1'b1);
      check("final_count", 32'(count), 0);
      check("final_pending", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
